// File: rtl/imem_dmem_arbiter_if.sv
// Pipeline-to-memory bundle for imem_dmem_arbiter: fetch port, MEM-stage data port
// and the shared single-port memory port. "slave" is the arbiter's view.
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;
  logic              flush;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one pipelined single-port memory between instruction fetch and the MEM stage.
// Optional ARB_PERF_EN adds free-running fetch-wait and conflict counters.
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  imem_dmem_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0] perf_fetch_wait,
  output logic [31:0] perf_conflict
`endif
);
  localparam int CNT_W    = $clog2(MEM_LAT + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                cancel_q, cancel_d;
  logic                we_q, we_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic if_ack_c, if_elig, d_elig, fetch_wins, dropped;

  // A flush landing in the ack cycle kills the pulse that is already on its way out.
  assign if_ack_c   = if_ack_q & ~bus.flush;
  assign if_elig    = bus.if_req & ~if_ack_c;
  assign d_elig     = bus.d_req & ~d_ack_q;
  assign fetch_wins = if_elig & (~d_elig | (starve_q == STARVE_W'(STARVE_MAX)));
  assign dropped    = cancel_q | bus.flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    cancel_d    = cancel_q;
    we_d        = we_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (fetch_wins) begin
          state_d    = BUSY_I;
          mem_addr_d = bus.if_addr;
          we_d       = 1'b0;
          mem_en_d   = 1'b1;
          cnt_d      = CNT_W'(MEM_LAT);
          starve_d   = '0;
        end else if (d_elig) begin
          state_d     = BUSY_D;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          we_d        = bus.d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.d_we;
          cnt_d       = CNT_W'(MEM_LAT);
          if (bus.if_req && (starve_q != STARVE_W'(STARVE_MAX)))
            starve_d = starve_q + STARVE_W'(1);
        end
      end
      BUSY_I: begin
        cancel_d = dropped;
        if (cnt_q == '0) begin
          state_d  = IDLE;
          cancel_d = 1'b0;
          if (!dropped) begin
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BUSY_D: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          d_ack_d = 1'b1;
          if (!we_q)
            d_rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      cancel_q    <= 1'b0;
      we_q        <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      cancel_q    <= cancel_d;
      we_q        <= we_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Stalls are gated by reset so the pipeline is released while the arbiter is held.
  assign bus.if_stall  = rst & bus.if_req & ~if_ack_c;
  assign bus.d_stall   = rst & bus.d_req & ~d_ack_q;
  assign bus.if_ack    = if_ack_c;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef ARB_PERF_EN
  logic [31:0] perf_fetch_wait_q, perf_conflict_q;
  logic        conflict_c;

  assign conflict_c = (state_q == IDLE) & if_elig & d_elig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_wait_q <= '0;
      perf_conflict_q   <= '0;
    end else begin
      perf_fetch_wait_q <= perf_fetch_wait_q + {31'b0, bus.if_stall};
      perf_conflict_q   <= perf_conflict_q + {31'b0, conflict_c};
    end
  end

  assign perf_fetch_wait = perf_fetch_wait_q;
  assign perf_conflict   = perf_conflict_q;
`endif
endmodule
